// File: rtl/tetris_input_ctrl.sv
// tetris_input_ctrl
// Turns four raw push-buttons into single-cycle command pulses for tetris_grid.
// Each button is synchronised with two flops, debounced with a counter and
// edge-detected. Left, right and down auto-repeat while held. Rotate fires
// once per press.
//
// Ports:
//   clk         system clock, single domain
//   reset       synchronous active-high reset
//   btn_left    raw buttons, active-high, asynchronous to clk
//   btn_right
//   btn_down
//   btn_rotate
//   game_over   from tetris_grid; while high every command output is held low
//   move_left   one-cycle command pulses, registered
//   move_right
//   move_down
//   rotate

module tetris_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 12_000_000,
    parameter int REPEAT_PERIOD   = 4_800_000,
    parameter int DOWN_PERIOD     = 2_400_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_down,
    input  logic btn_rotate,
    input  logic game_over,
    output logic move_left,
    output logic move_right,
    output logic move_down,
    output logic rotate
);

    localparam int DB_W      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int MAX_RPT   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TIMER_MAX = (MAX_RPT > DOWN_PERIOD) ? MAX_RPT : DOWN_PERIOD;
    localparam int TMR_W     = $clog2(TIMER_MAX);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RPT_LAST   = TMR_W'(REPEAT_PERIOD - 1);
    localparam logic [TMR_W-1:0] DOWN_LAST  = TMR_W'(DOWN_PERIOD - 1);

    // Button slot indices shared by every per-button vector below.
    localparam int B_LEFT   = 0;
    localparam int B_RIGHT  = 1;
    localparam int B_DOWN   = 2;
    localparam int B_ROTATE = 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic [3:0]       btn_raw;
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [3:0]       db_q, db_d;
    logic [DB_W-1:0]  db_cnt_q [4];
    logic [DB_W-1:0]  db_cnt_d [4];
    logic [1:0]       state_q [3];
    logic [1:0]       state_d [3];
    logic [TMR_W-1:0] timer_q [3];
    logic [TMR_W-1:0] timer_d [3];
    logic             rot_prev_q, rot_prev_d;
    logic [3:0]       fire_q, fire_d;
    logic [3:0]       out_q, out_d;
    logic             lr_conflict;

    assign btn_raw = {btn_rotate, btn_down, btn_right, btn_left};

    // Two-flop synchronisers, one pair per button.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

    // Debounce: the counter measures how long the synchronised input has
    // disagreed with the debounced level. Any agreement restarts the count, so
    // only an uninterrupted run of DEBOUNCE_CYCLES disagreeing cycles flips it.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Auto-repeat FSMs for left, right and down. Releasing the button always
    // wins, so IDLE can only see a high level on a fresh press.
    always_comb begin
        fire_d     = '0;
        rot_prev_d = db_q[B_ROTATE];
        for (int i = 0; i < 3; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            if (!db_q[i]) begin
                state_d[i] = ST_IDLE;
                timer_d[i] = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        fire_d[i]  = 1'b1;
                        timer_d[i] = DELAY_LAST;
                        state_d[i] = ST_DELAY;
                    end
                    ST_DELAY, ST_REPEAT: begin
                        if (timer_q[i] == '0) begin
                            fire_d[i]  = 1'b1;
                            timer_d[i] = (i == B_DOWN) ? DOWN_LAST : RPT_LAST;
                            state_d[i] = ST_REPEAT;
                        end else begin
                            timer_d[i] = timer_q[i] - TMR_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        timer_d[i] = '0;
                    end
                endcase
            end
        end
        // Rotate never repeats: one pulse per debounced rising edge.
        fire_d[B_ROTATE] = db_q[B_ROTATE] & ~rot_prev_q;
    end

    // Output stage. Masked pulses are simply dropped; the FSMs keep their
    // schedule, so a later unmasked pulse arrives exactly when it was due.
    always_comb begin
        lr_conflict      = db_q[B_LEFT] & db_q[B_RIGHT];
        out_d[B_LEFT]    = fire_q[B_LEFT]   & ~game_over & ~lr_conflict;
        out_d[B_RIGHT]   = fire_q[B_RIGHT]  & ~game_over & ~lr_conflict;
        out_d[B_DOWN]    = fire_q[B_DOWN]   & ~game_over;
        out_d[B_ROTATE]  = fire_q[B_ROTATE] & ~game_over;
    end

    // All state registers with a synchronous reset that aborts any debounce or
    // repeat in progress; a button still held afterwards looks like a new press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            rot_prev_q <= 1'b0;
            fire_q     <= '0;
            out_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                state_q[i] <= ST_IDLE;
                timer_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_q       <= db_d;
            rot_prev_q <= rot_prev_d;
            fire_q     <= fire_d;
            out_q      <= out_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
        end
    end

    assign move_left  = out_q[B_LEFT];
    assign move_right = out_q[B_RIGHT];
    assign move_down  = out_q[B_DOWN];
    assign rotate     = out_q[B_ROTATE];

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Testbench for tetris_input_ctrl with small timing parameters.
// A cycle-level behavioural model predicts all four outputs. Directed
// scenarios also check hand-computed pulse times and counts.

module tb_tetris_input_ctrl;

    localparam int DBC = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;
    localparam int DP  = 3;

    logic clk = 1'b0;
    logic reset;
    logic btn_left, btn_right, btn_down, btn_rotate, game_over;
    logic move_left, move_right, move_down, rotate;
    logic [3:0] dutOut;

    int cyc = 0;
    int ckTotal = 0;
    int ckPass = 0;

    int leftQ[$];
    int rightQ[$];
    int downQ[$];
    int rotQ[$];

    tetris_input_ctrl #(
        .DEBOUNCE_CYCLES(DBC),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP),
        .DOWN_PERIOD(DP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_down(btn_down),
        .btn_rotate(btn_rotate),
        .game_over(game_over),
        .move_left(move_left),
        .move_right(move_right),
        .move_down(move_down),
        .rotate(rotate)
    );

    assign dutOut = {rotate, move_down, move_right, move_left};

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Behavioural model: raw levels seen two edges ago, a run-length debounce,
    // and a pulse schedule expressed as "how many edges has the button been
    // debounced high".
    bit mS1[4], mS2[4], mDb[4], mFire[4], mOut[4];
    int mRun[4], mHold[4];
    bit mValid = 1'b0;

    function automatic bit firesAt(int idx, int h);
        int per;
        if (h == 0) return 1'b0;
        if (h == 1) return 1'b1;
        if (idx == 3) return 1'b0;
        per = (idx == 2) ? DP : RP;
        if (h == 1 + RD) return 1'b1;
        if (h > 1 + RD && ((h - 1 - RD) % per) == 0) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin : model
        bit raw[4];
        bit conflict;
        raw[0] = btn_left;
        raw[1] = btn_right;
        raw[2] = btn_down;
        raw[3] = btn_rotate;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                mS1[i] = 0; mS2[i] = 0; mDb[i] = 0; mFire[i] = 0;
                mOut[i] = 0; mRun[i] = 0; mHold[i] = 0;
            end
            mValid = 1'b1;
        end else begin
            conflict = mDb[0] && mDb[1];
            mOut[0] = mFire[0] && !game_over && !conflict;
            mOut[1] = mFire[1] && !game_over && !conflict;
            mOut[2] = mFire[2] && !game_over;
            mOut[3] = mFire[3] && !game_over;
            for (int i = 0; i < 4; i++) begin
                mHold[i] = mDb[i] ? mHold[i] + 1 : 0;
                mFire[i] = firesAt(i, mHold[i]);
            end
            for (int i = 0; i < 4; i++) begin
                if (mS2[i] != mDb[i]) begin
                    mRun[i]++;
                    if (mRun[i] == DBC) begin
                        mDb[i] = mS2[i];
                        mRun[i] = 0;
                    end
                end else begin
                    mRun[i] = 0;
                end
                mS2[i] = mS1[i];
                mS1[i] = raw[i];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        ckTotal++;
        if (act === exp) ckPass++;
        else $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    // Every-cycle comparison against the model, plus pulse-time logging.
    always @(negedge clk) begin
        if (mValid) begin
            checkOutput("move_left", {31'b0, dutOut[0]}, {31'b0, mOut[0]});
            checkOutput("move_right", {31'b0, dutOut[1]}, {31'b0, mOut[1]});
            checkOutput("move_down", {31'b0, dutOut[2]}, {31'b0, mOut[2]});
            checkOutput("rotate", {31'b0, dutOut[3]}, {31'b0, mOut[3]});
            if (dutOut[0] === 1'b1) leftQ.push_back(cyc);
            if (dutOut[1] === 1'b1) rightQ.push_back(cyc);
            if (dutOut[2] === 1'b1) downQ.push_back(cyc);
            if (dutOut[3] === 1'b1) rotQ.push_back(cyc);
        end
    end

    task automatic applyStimulus(input bit l, input bit r, input bit d, input bit rot, input bit go);
        btn_left = l;
        btn_right = r;
        btn_down = d;
        btn_rotate = rot;
        game_over = go;
    endtask

    task automatic holdCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitPulse(input int idx, input int budget, input string name, output int t);
        bit found;
        found = 1'b0;
        t = -1;
        for (int k = 0; k < budget && !found; k++) begin
            @(negedge clk);
            if (dutOut[idx] === 1'b1) begin
                found = 1'b1;
                t = cyc;
            end
        end
        checkOutput(name, {31'b0, found}, 32'd1);
    endtask

    int s, t, n0, l0, r0, cnt, tFirst;

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        holdCycles(3);
        reset = 1'b0;
        checkOutput("reset_outputs", {28'b0, dutOut}, 32'd0);

        // Rotate: one pulse per press, fixed latency.
        holdCycles(1);
        n0 = rotQ.size();
        applyStimulus(0, 0, 0, 1, 0);
        s = cyc;
        waitPulse(3, 30, "rotate_wait", t);
        checkOutput("rotate_latency", t - s - 1, 7);
        holdCycles(100);
        checkOutput("rotate_single", rotQ.size() - n0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        holdCycles(12);
        applyStimulus(0, 0, 0, 1, 0);
        s = cyc;
        waitPulse(3, 30, "rotate_repress_wait", t);
        checkOutput("rotate_repress_latency", t - s - 1, 7);
        holdCycles(5);
        applyStimulus(0, 0, 0, 0, 0);
        holdCycles(12);

        // Short glitch on left never gets through.
        n0 = leftQ.size();
        applyStimulus(1, 0, 0, 0, 0);
        holdCycles(3);
        applyStimulus(0, 0, 0, 0, 0);
        holdCycles(20);
        checkOutput("left_glitch", leftQ.size() - n0, 0);

        // Left held 40 cycles: pulses at +8, +18, then every 5.
        n0 = leftQ.size();
        applyStimulus(1, 0, 0, 0, 0);
        s = cyc;
        holdCycles(40);
        applyStimulus(0, 0, 0, 0, 0);
        holdCycles(15);
        checkOutput("left_count", leftQ.size() - n0, 7);
        if (leftQ.size() - n0 >= 4) begin
            checkOutput("left_latency", leftQ[n0] - s - 1, 7);
            checkOutput("left_gap1", leftQ[n0+1] - leftQ[n0], RD);
            checkOutput("left_gap2", leftQ[n0+2] - leftQ[n0+1], RP);
            checkOutput("left_gap3", leftQ[n0+3] - leftQ[n0+2], RP);
        end else begin
            checkOutput("left_schedule_len", leftQ.size() - n0, 4);
        end

        // Down held 30 cycles: delay then 3-cycle period, left/right quiet.
        n0 = downQ.size();
        l0 = leftQ.size();
        r0 = rightQ.size();
        applyStimulus(0, 0, 1, 0, 0);
        s = cyc;
        holdCycles(30);
        applyStimulus(0, 0, 0, 0, 0);
        holdCycles(15);
        checkOutput("down_count", downQ.size() - n0, 8);
        if (downQ.size() - n0 >= 4) begin
            checkOutput("down_latency", downQ[n0] - s - 1, 7);
            checkOutput("down_gap1", downQ[n0+1] - downQ[n0], RD);
            checkOutput("down_gap2", downQ[n0+2] - downQ[n0+1], DP);
            checkOutput("down_gap3", downQ[n0+3] - downQ[n0+2], DP);
        end else begin
            checkOutput("down_schedule_len", downQ.size() - n0, 4);
        end
        checkOutput("down_no_lr", (leftQ.size() - l0) + (rightQ.size() - r0), 0);

        // Left held, right added mid-repeat, then right released.
        l0 = leftQ.size();
        r0 = rightQ.size();
        applyStimulus(1, 0, 0, 0, 0);
        s = cyc;
        holdCycles(20);
        applyStimulus(1, 1, 0, 0, 0);
        holdCycles(20);
        applyStimulus(1, 0, 0, 0, 0);
        holdCycles(15);
        applyStimulus(0, 0, 0, 0, 0);
        holdCycles(15);
        checkOutput("conflict_right_count", rightQ.size() - r0, 0);
        cnt = 0;
        tFirst = -1;
        for (int k = l0; k < leftQ.size(); k++) begin
            if (leftQ[k] > s + 26 && leftQ[k] < s + 47) cnt++;
            if (tFirst < 0 && leftQ[k] > s + 40) tFirst = leftQ[k];
        end
        checkOutput("conflict_left_masked", cnt, 0);
        checkOutput("conflict_left_resume", tFirst - s, 48);
        checkOutput("conflict_left_count", leftQ.size() - l0, 6);

        // game_over masks right, then deassertion resumes on schedule.
        r0 = rightQ.size();
        applyStimulus(0, 1, 0, 0, 1);
        s = cyc;
        holdCycles(25);
        applyStimulus(0, 1, 0, 0, 0);
        holdCycles(10);
        applyStimulus(0, 0, 0, 0, 0);
        holdCycles(15);
        checkOutput("gameover_right_count", rightQ.size() - r0, 3);
        if (rightQ.size() > r0) checkOutput("gameover_resume", rightQ[r0] - s, 28);
        else checkOutput("gameover_resume_missing", rightQ.size() - r0, 1);

        // Reset mid-DELAY while left is held; left re-fires as a new press.
        applyStimulus(1, 0, 0, 0, 0);
        s = cyc;
        waitPulse(0, 30, "reset_pre_wait", t);
        checkOutput("reset_pre_latency", t - s - 1, 7);
        holdCycles(3);
        reset = 1'b1;
        holdCycles(1);
        reset = 1'b0;
        s = cyc;
        checkOutput("reset_mid_outputs", {28'b0, dutOut}, 32'd0);
        waitPulse(0, 30, "reset_refire_wait", t);
        checkOutput("reset_refire_latency", t - s - 1, 7);
        applyStimulus(0, 0, 0, 0, 0);
        holdCycles(15);

        $display("%0d/%0d checks passed", ckPass, ckTotal);
        $finish;
    end

endmodule
